// File: rtl/misao_mem_responder.sv
// misao_mem_responder
// Memory-side responder for the MISA-O nibble-serial core. It serves 4-bit
// reads and writes from the core and bridges them onto a byte-wide external
// port that uses a req/ack handshake. A one-byte line buffer holds the last
// byte that was touched, so the sibling nibble can be read without another
// fetch. Nibble stores are done as read-modify-write of the whole byte.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   mem_addr          core nibble address ([15:1] byte, [0] nibble select)
//   mem_rw            1 = read, 0 = write (sampled in IDLE only)
//   mem_data_out      core store nibble
//   mem_data_in       read nibble to core, valid while mem_enable_read=1
//   mem_enable_read   one-cycle read-data strobe
//   mem_enable_write  high while the responder can take a request
//   ext_req/ext_we    external request / write enable (held until ext_ack)
//   ext_addr/ext_wdata external byte address / write byte (registered)
//   ext_rdata/ext_ack external read byte / one-cycle completion
//   proto_err         sticky: a store was seen outside IDLE
module misao_mem_responder #(
  parameter int LINE_BUF = 1,
  parameter int EXT_AW   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       mem_addr,
  input  logic              mem_rw,
  input  logic [3:0]        mem_data_out,
  output logic [3:0]        mem_data_in,
  output logic              mem_enable_read,
  output logic              mem_enable_write,
  output logic              ext_req,
  output logic              ext_we,
  output logic [EXT_AW-1:0] ext_addr,
  output logic [7:0]        ext_wdata,
  input  logic [7:0]        ext_rdata,
  input  logic              ext_ack,
  output logic              proto_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_FETCH = 3'd1,
    RESP     = 3'd2,
    WR_RD    = 3'd3,
    WR_REQ   = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_lb_valid;
  logic [EXT_AW-1:0] r_lb_tag;
  logic [7:0]        r_lb_data;
  logic [EXT_AW:0]   r_wa;       // captured core address (byte + nibble select)
  logic [3:0]        r_wd;       // captured store nibble
  logic [3:0]        r_rdata;
  logic [EXT_AW-1:0] r_ext_addr;
  logic [7:0]        r_ext_wdata;
  logic              r_proto_err;

  logic [EXT_AW-1:0] w_baddr;
  logic              w_hit;

  assign w_baddr = mem_addr[EXT_AW:1];
  assign w_hit   = (LINE_BUF != 0) && r_lb_valid && (r_lb_tag == w_baddr);

  // Replace one nibble of a byte, leaving the other one untouched.
  function automatic logic [7:0] f_merge(input logic [7:0] b, input logic sel,
                                         input logic [3:0] n);
    f_merge = sel ? {n, b[3:0]} : {b[7:4], n};
  endfunction

  function automatic logic [3:0] f_pick(input logic [7:0] b, input logic sel);
    f_pick = sel ? b[7:4] : b[3:0];
  endfunction

  // Handshake outputs decode straight from the state register, so they are
  // glitch-free and need no separate output flops.
  assign mem_enable_write = (r_state == IDLE);
  assign mem_enable_read  = (r_state == RESP);
  assign ext_req          = (r_state == RD_FETCH) || (r_state == WR_RD) ||
                            (r_state == WR_REQ);
  assign ext_we           = (r_state == WR_REQ);
  assign ext_addr         = r_ext_addr;
  assign ext_wdata        = r_ext_wdata;
  assign mem_data_in      = r_rdata;
  assign proto_err        = r_proto_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lb_valid  <= 1'b0;
      r_lb_tag    <= '0;
      r_lb_data   <= '0;
      r_wa        <= '0;
      r_wd        <= '0;
      r_rdata     <= '0;
      r_ext_addr  <= '0;
      r_ext_wdata <= '0;
      r_proto_err <= 1'b0;
    end else begin
      // A store outside IDLE is dropped; only the flag records it.
      if (!mem_rw && (r_state != IDLE))
        r_proto_err <= 1'b1;

      case (r_state)
        IDLE: begin
          r_wa <= mem_addr[EXT_AW:0];
          if (mem_rw) begin
            if (w_hit) begin
              // Data is loaded on the way into RESP so it is valid with the strobe.
              r_rdata <= f_pick(r_lb_data, mem_addr[0]);
              r_state <= RESP;
            end else begin
              r_ext_addr <= w_baddr;
              r_state    <= RD_FETCH;
            end
          end else begin
            r_wd       <= mem_data_out;
            r_ext_addr <= w_baddr;
            if (w_hit) begin
              r_ext_wdata <= f_merge(r_lb_data, mem_addr[0], mem_data_out);
              r_state     <= WR_REQ;
            end else begin
              r_state <= WR_RD;
            end
          end
        end

        RD_FETCH: begin
          if (ext_ack) begin
            r_lb_valid <= 1'b1;
            r_lb_tag   <= r_wa[EXT_AW:1];
            r_lb_data  <= ext_rdata;
            r_rdata    <= f_pick(ext_rdata, r_wa[0]);
            r_state    <= RESP;
          end
        end

        // mem_addr is not looked at here: the core moves its address on
        // this edge, so the next request is sampled back in IDLE.
        RESP: r_state <= IDLE;

        WR_RD: begin
          if (ext_ack) begin
            r_ext_wdata <= f_merge(ext_rdata, r_wa[0], r_wd);
            r_state     <= WR_REQ;
          end
        end

        WR_REQ: begin
          if (ext_ack) begin
            r_lb_valid <= 1'b1;
            r_lb_tag   <= r_wa[EXT_AW:1];
            r_lb_data  <= r_ext_wdata;
            r_state    <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_misao_mem_responder.sv
module tb_misao_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_rw;
  logic [3:0]  mem_data_out;
  logic [3:0]  mem_data_in;
  logic        mem_enable_read;
  logic        mem_enable_write;
  logic        ext_req;
  logic        ext_we;
  logic [14:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic [7:0]  ext_rdata;
  logic        ext_ack;
  logic        proto_err;

  misao_mem_responder #(.LINE_BUF(1), .EXT_AW(15)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rw(mem_rw),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // External byte memory and transaction scoreboards
  logic [7:0] xmem [0:255];
  typedef struct { logic [14:0] a; logic [7:0] d; } wr_t;
  wr_t        wr_q [$];
  logic [3:0] rd_q [$];
  int  ext_rd_cnt = 0;
  int  ext_wr_cnt = 0;
  int  ack_dly    = 1;
  bit  inject_ack = 1'b0;

  // External memory: acks after ack_dly waiting cycles, one-cycle ack.
  initial begin
    int wcnt;
    wr_t w;
    wcnt = 0; ext_ack = 1'b0; ext_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (inject_ack) begin
        ext_ack = 1'b1; ext_rdata = 8'hEE; inject_ack = 1'b0;
      end else if (ext_ack) begin
        ext_ack = 1'b0; wcnt = 0;
      end else if (ext_req) begin
        if (wcnt >= ack_dly) begin
          ext_ack   = 1'b1;
          ext_rdata = xmem[ext_addr[7:0]];
          if (ext_we) begin
            ext_wr_cnt++;
            if (wr_q.size() == 0) begin
              n_chk++;
              $display("FAIL unexpected_ext_write: got addr %0h data %0h expected none", ext_addr, ext_wdata);
            end else begin
              w = wr_q.pop_front();
              chk("ext_wr_addr", ext_addr, w.a);
              chk("ext_wr_data", ext_wdata, w.d);
            end
            xmem[ext_addr[7:0]] = ext_wdata;
          end else begin
            ext_rd_cnt++;
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Read-data scoreboard: compare only strobes the bench asked for.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (mem_enable_read && rd_q.size() > 0) begin
        e = rd_q.pop_front();
        chk("rd_data", mem_data_in, e);
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    do begin @(posedge clk); #1; k++; end while (!mem_enable_write && k < 100);
    if (!mem_enable_write) begin n_chk++; $display("FAIL wait_idle: got busy expected idle"); end
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_enable_read && n < 60);
    if (!mem_enable_read) begin n_chk++; $display("FAIL strobe_timeout: got none expected strobe"); end
    #1;
  endtask

  task automatic do_read(input logic [15:0] a, input logic [3:0] exp, input bit hit);
    int rc0, n;
    wait_idle();
    mem_addr = a; mem_rw = 1'b1;
    rc0 = ext_rd_cnt;
    rd_q.push_back(exp);
    @(posedge clk);
    wait_strobe(n);
    chk("rd_q_drained", rd_q.size(), 0);
    if (hit) begin
      chk("hit_latency", n, 1);
      chk("hit_ext_reads", ext_rd_cnt - rc0, 0);
    end else begin
      chk("miss_latency", n, 2 + ack_dly);
      chk("miss_ext_reads", ext_rd_cnt - rc0, 1);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [3:0] d, input bit hit,
                          input logic [7:0] bd);
    int rc0, wc0, k;
    wr_t w;
    wait_idle();
    mem_addr = a; mem_rw = 1'b0; mem_data_out = d;
    rc0 = ext_rd_cnt; wc0 = ext_wr_cnt;
    w.a = a[15:1]; w.d = bd;
    wr_q.push_back(w);
    @(posedge clk); #1;
    mem_rw = 1'b1; mem_data_out = 4'h0;
    k = 0;
    while (ext_wr_cnt == wc0 && k < 60) begin @(negedge clk); k++; end
    chk("wr_ext_writes", ext_wr_cnt - wc0, 1);
    chk("wr_ext_reads", ext_rd_cnt - rc0, hit ? 0 : 1);
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [3:0]  data;   // store nibble or expected read nibble
    bit          hit;
    logic [7:0]  byte_w; // expected external write byte
  } vec_t;

  vec_t vecs [12];

  initial begin
    int n, rc0, wc0;
    vecs[0]  = '{1'b0, 16'h0020, 4'h5, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 16'h0021, 4'hA, 1'b1, 8'h00};
    vecs[2]  = '{1'b1, 16'h0020, 4'hF, 1'b1, 8'hAF};
    vecs[3]  = '{1'b0, 16'h0020, 4'hF, 1'b1, 8'h00};
    vecs[4]  = '{1'b0, 16'h0021, 4'hA, 1'b1, 8'h00};
    vecs[5]  = '{1'b1, 16'h0041, 4'h3, 1'b0, 8'h3C};
    vecs[6]  = '{1'b0, 16'h0040, 4'hC, 1'b1, 8'h00};
    vecs[7]  = '{1'b0, 16'h0041, 4'h3, 1'b1, 8'h00};
    vecs[8]  = '{1'b0, 16'h0020, 4'hF, 1'b0, 8'h00};
    vecs[9]  = '{1'b1, 16'h0001, 4'h9, 1'b0, 8'h90};
    vecs[10] = '{1'b0, 16'h0000, 4'h0, 1'b1, 8'h00};
    vecs[11] = '{1'b0, 16'h0001, 4'h9, 1'b1, 8'h00};

    for (int i = 0; i < 256; i++) xmem[i] = 8'h00;
    xmem[8'h10] = 8'hA5;
    xmem[8'h20] = 8'h7C;
    xmem[8'h40] = 8'h5B;

    rst = 1'b1; mem_addr = 16'h0000; mem_rw = 1'b1; mem_data_out = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_enable_write", mem_enable_write, 1);
    chk("rst_enable_read", mem_enable_read, 0);
    chk("rst_ext_req", ext_req, 0);
    chk("rst_ext_we", ext_we, 0);
    chk("rst_ext_addr", ext_addr, 0);
    chk("rst_ext_wdata", ext_wdata, 0);
    chk("rst_data_in", mem_data_in, 0);
    chk("rst_proto_err", proto_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    // First request after reset must go external.
    @(posedge clk); #1;
    chk("first_req_misses", ext_req, 1);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].hit, vecs[i].byte_w);
      else            do_read(vecs[i].addr, vecs[i].data, vecs[i].hit);
    end

    // Store attempted during a read fetch: flagged, dropped, read unaffected.
    ack_dly = 3;
    wait_idle();
    mem_addr = 16'h0081; mem_rw = 1'b1;
    rd_q.push_back(4'h5);
    rc0 = ext_rd_cnt; wc0 = ext_wr_cnt;
    @(posedge clk); #1;
    chk("pe_in_fetch", ext_req, 1);
    mem_rw = 1'b0; mem_data_out = 4'h1;
    @(posedge clk); #1;
    mem_rw = 1'b1;
    chk("pe_set", proto_err, 1);
    wait_strobe(n);
    chk("pe_rd_drained", rd_q.size(), 0);
    chk("pe_ext_reads", ext_rd_cnt - rc0, 1);
    chk("pe_no_ext_write", ext_wr_cnt - wc0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("pe_sticky", proto_err, 1);

    // Reset in the middle of a slow fetch; a late ack must be ignored.
    ack_dly = 5;
    wait_idle();
    mem_addr = 16'h0101;
    @(posedge clk); #1;
    chk("rstmid_req", ext_req, 1);
    chk("rstmid_addr", ext_addr, 15'h0080);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    inject_ack = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_req_dropped", ext_req, 0);
    chk("rstmid_pe_clear", proto_err, 0);
    chk("rstmid_idle", mem_enable_write, 1);
    rst = 1'b0;
    ack_dly = 1;
    mem_addr = 16'h0021;
    rd_q.push_back(4'hA);
    rc0 = ext_rd_cnt;
    @(posedge clk);
    wait_strobe(n);
    chk("rstmid_rd_drained", rd_q.size(), 0);
    chk("rstmid_misses", ext_rd_cnt - rc0, 1);

    repeat (4) @(posedge clk);
    chk("wr_q_empty", wr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
